// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared defaults, forward-select encoding and scoreboard entry
//               type for the hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam int DEF_REG_AW = 5;
    localparam int DEF_TW     = 2;
    localparam int DEF_SW     = 2;
    localparam int FWD_RF     = 0;

    typedef struct packed {
        logic                  valid;
        logic [DEF_REG_AW-1:0] dst;
        logic [DEF_TW-1:0]     tnew;
    } sb_entry_t;

    // One pipeline step closer to producing its result, floored at zero.
    function automatic logic [DEF_TW-1:0] tnew_dec(input logic [DEF_TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_match.sv
// ============================================================================
// Module      : hazard_match
// Description : Priority search over scoreboard entries for one D operand;
//               returns the newest (lowest-index) matching writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_match
    import hazard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REG_AW = DEF_REG_AW,
    parameter int TW     = DEF_TW,
    parameter int SW     = DEF_SW
) (
    input  logic [STAGES-1:0]        i_valid,
    input  logic [STAGES*REG_AW-1:0] i_dst,
    input  logic [STAGES*TW-1:0]     i_tnew,
    input  logic [REG_AW-1:0]        i_src,
    input  logic                     i_use,
    input  logic                     i_d_valid,
    output logic                     o_hit,
    output logic [SW-1:0]            o_idx,
    output logic [TW-1:0]            o_tnew
);

    always_comb begin
        o_hit  = 1'b0;
        o_idx  = SW'(FWD_RF);
        o_tnew = '0;
        // Walk oldest to newest so the youngest matching writer wins.
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (i_valid[k] && (i_dst[k*REG_AW +: REG_AW] == i_src) &&
                (i_src != '0) && i_use && i_d_valid) begin
                o_hit  = 1'b1;
                o_idx  = SW'(k + 1);
                o_tnew = i_tnew[k*TW +: TW];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : Stall/forward controller tracking in-flight register writers
//               in E..W. Optional stall-cycle counter under HAZARD_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REG_AW = DEF_REG_AW,
    parameter int TW     = DEF_TW,
    parameter int SW     = DEF_SW
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              D_Valid_In,
    input  logic [REG_AW-1:0] D_Rs_In,
    input  logic [REG_AW-1:0] D_Rt_In,
    input  logic              D_Use_Rs_In,
    input  logic              D_Use_Rt_In,
    input  logic [TW-1:0]     D_Tuse_Rs_In,
    input  logic [TW-1:0]     D_Tuse_Rt_In,
    input  logic              D_RegWrite_In,
    input  logic [REG_AW-1:0] D_Dst_In,
    input  logic [TW-1:0]     D_Tnew_In,
    output logic              Stall_Out,
    output logic [SW-1:0]     Fwd_Rs_Sel_Out,
    output logic [SW-1:0]     Fwd_Rt_Sel_Out
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       Stall_Cnt_Out
`endif
);

    sb_entry_t r_sb [STAGES];

    logic [STAGES-1:0]        w_valid;
    logic [STAGES*REG_AW-1:0] w_dst;
    logic [STAGES*TW-1:0]     w_tnew;

    logic              w_rs_hit, w_rt_hit;
    logic [SW-1:0]     w_rs_idx, w_rt_idx;
    logic [TW-1:0]     w_rs_tnew, w_rt_tnew;
    logic              w_stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_flat
        assign w_valid[k]                  = r_sb[k].valid;
        assign w_dst[k*REG_AW +: REG_AW]   = r_sb[k].dst;
        assign w_tnew[k*TW +: TW]          = r_sb[k].tnew;
    end

    hazard_match #(.STAGES(STAGES), .REG_AW(REG_AW), .TW(TW), .SW(SW)) u_match_rs (
        .i_valid   (w_valid),
        .i_dst     (w_dst),
        .i_tnew    (w_tnew),
        .i_src     (D_Rs_In),
        .i_use     (D_Use_Rs_In),
        .i_d_valid (D_Valid_In),
        .o_hit     (w_rs_hit),
        .o_idx     (w_rs_idx),
        .o_tnew    (w_rs_tnew)
    );

    hazard_match #(.STAGES(STAGES), .REG_AW(REG_AW), .TW(TW), .SW(SW)) u_match_rt (
        .i_valid   (w_valid),
        .i_dst     (w_dst),
        .i_tnew    (w_tnew),
        .i_src     (D_Rt_In),
        .i_use     (D_Use_Rt_In),
        .i_d_valid (D_Valid_In),
        .o_hit     (w_rt_hit),
        .o_idx     (w_rt_idx),
        .o_tnew    (w_rt_tnew)
    );

    assign w_stall = (w_rs_hit && (w_rs_tnew > D_Tuse_Rs_In)) ||
                     (w_rt_hit && (w_rt_tnew > D_Tuse_Rt_In));

    assign Stall_Out      = w_stall;
    assign Fwd_Rs_Sel_Out = (!w_stall && w_rs_hit && (w_rs_tnew == '0)) ? w_rs_idx : SW'(FWD_RF);
    assign Fwd_Rt_Sel_Out = (!w_stall && w_rt_hit && (w_rt_tnew == '0)) ? w_rt_idx : SW'(FWD_RF);

    // A stall injects a bubble into E while older writers keep draining.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_sb[k] <= '0;
            end
        end else begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                r_sb[k] <= sb_entry_t'{valid: r_sb[k-1].valid,
                                       dst:   r_sb[k-1].dst,
                                       tnew:  tnew_dec(r_sb[k-1].tnew)};
            end
            if (w_stall) begin
                r_sb[0] <= '0;
            end else begin
                r_sb[0] <= sb_entry_t'{valid: D_Valid_In & D_RegWrite_In & (D_Dst_In != '0),
                                       dst:   D_Dst_In,
                                       tnew:  D_Tnew_In};
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign Stall_Cnt_Out = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    localparam int STAGES = 3;
    localparam int REG_AW = 5;
    localparam int TW     = 2;
    localparam int SW     = 2;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              D_Valid_In;
    logic [REG_AW-1:0] D_Rs_In, D_Rt_In, D_Dst_In;
    logic              D_Use_Rs_In, D_Use_Rt_In, D_RegWrite_In;
    logic [TW-1:0]     D_Tuse_Rs_In, D_Tuse_Rt_In, D_Tnew_In;
    logic              Stall_Out;
    logic [SW-1:0]     Fwd_Rs_Sel_Out, Fwd_Rt_Sel_Out;
`ifdef HAZARD_STATS_EN
    logic [31:0]       Stall_Cnt_Out;
    int                pin_cnt = -1;
`endif

    hazard_scoreboard #(.STAGES(STAGES), .REG_AW(REG_AW), .TW(TW), .SW(SW)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .D_Valid_In     (D_Valid_In),
        .D_Rs_In        (D_Rs_In),
        .D_Rt_In        (D_Rt_In),
        .D_Use_Rs_In    (D_Use_Rs_In),
        .D_Use_Rt_In    (D_Use_Rt_In),
        .D_Tuse_Rs_In   (D_Tuse_Rs_In),
        .D_Tuse_Rt_In   (D_Tuse_Rt_In),
        .D_RegWrite_In  (D_RegWrite_In),
        .D_Dst_In       (D_Dst_In),
        .D_Tnew_In      (D_Tnew_In),
        .Stall_Out      (Stall_Out),
        .Fwd_Rs_Sel_Out (Fwd_Rs_Sel_Out),
        .Fwd_Rt_Sel_Out (Fwd_Rt_Sel_Out)
`ifdef HAZARD_STATS_EN
        ,
        .Stall_Cnt_Out  (Stall_Cnt_Out)
`endif
    );

    always #5 Clk = ~Clk;

    // Model: list of accepted writers with the cycle they entered E.
    typedef struct {
        int dst;
        int tnew;
        int enter;
    } wr_t;

    wr_t wq[$];
    int  cyc     = 0;
    int  m_cnt   = 0;
    bit  m_stall = 1'b0;
    bit  started = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    bit pin_en = 1'b0;
    int pin_stall, pin_rs, pin_rt;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(posedge Clk) begin
        if (Reset) begin
            wq.delete();
            m_cnt = 0;
        end else begin
            if (m_stall) m_cnt++;
            cyc++;
            if (!m_stall && D_Valid_In && D_RegWrite_In && (D_Dst_In != 0))
                wq.push_back('{int'(D_Dst_In), int'(D_Tnew_In), cyc});
        end
        started = 1'b1;
    end

    always @(negedge Clk) begin
        if (started) begin
            int rs_age, rt_age, rs_t, rt_t, e_rs, e_rt;
            bit e_stall;
            rs_age = 0; rt_age = 0; rs_t = 0; rt_t = 0;
            foreach (wq[i]) begin
                int age, tn;
                age = cyc - wq[i].enter + 1;
                tn  = (wq[i].tnew > age - 1) ? wq[i].tnew - (age - 1) : 0;
                if (age >= 1 && age <= STAGES && wq[i].dst != 0 && D_Valid_In) begin
                    if (D_Use_Rs_In && wq[i].dst == D_Rs_In && (rs_age == 0 || age < rs_age)) begin
                        rs_age = age; rs_t = tn;
                    end
                    if (D_Use_Rt_In && wq[i].dst == D_Rt_In && (rt_age == 0 || age < rt_age)) begin
                        rt_age = age; rt_t = tn;
                    end
                end
            end
            e_stall = (rs_age != 0 && rs_t > D_Tuse_Rs_In) || (rt_age != 0 && rt_t > D_Tuse_Rt_In);
            e_rs    = (!e_stall && rs_age != 0 && rs_t == 0) ? rs_age : 0;
            e_rt    = (!e_stall && rt_age != 0 && rt_t == 0) ? rt_age : 0;
            m_stall = e_stall;
            chk("model_stall", Stall_Out, e_stall);
            chk("model_fwd_rs", Fwd_Rs_Sel_Out, e_rs);
            chk("model_fwd_rt", Fwd_Rt_Sel_Out, e_rt);
            if (pin_en) begin
                chk("pin_stall", Stall_Out, pin_stall);
                chk("pin_fwd_rs", Fwd_Rs_Sel_Out, pin_rs);
                chk("pin_fwd_rt", Fwd_Rt_Sel_Out, pin_rt);
            end
`ifdef HAZARD_STATS_EN
            chk("model_stall_cnt", Stall_Cnt_Out, m_cnt);
            if (pin_cnt >= 0) chk("pin_stall_cnt", Stall_Cnt_Out, pin_cnt);
`endif
        end
    end

    task automatic drive(input int rst, input int v, input int rs, input int urs, input int trs,
                         input int rt, input int urt, input int trt,
                         input int rw, input int dst, input int tn);
        Reset         = rst[0];
        D_Valid_In    = v[0];
        D_Rs_In       = REG_AW'(rs);
        D_Use_Rs_In   = urs[0];
        D_Tuse_Rs_In  = TW'(trs);
        D_Rt_In       = REG_AW'(rt);
        D_Use_Rt_In   = urt[0];
        D_Tuse_Rt_In  = TW'(trt);
        D_RegWrite_In = rw[0];
        D_Dst_In      = REG_AW'(dst);
        D_Tnew_In     = TW'(tn);
    endtask

    // Advance one cycle, apply new D inputs and optional literal expectations.
    task automatic step(input int rst, input int v, input int rs, input int urs, input int trs,
                        input int rt, input int urt, input int trt,
                        input int rw, input int dst, input int tn,
                        input int pe, input int ps, input int prs, input int prt);
        @(posedge Clk);
        #1;
        drive(rst, v, rs, urs, trs, rt, urt, trt, rw, dst, tn);
        pin_en    = pe[0];
        pin_stall = ps;
        pin_rs    = prs;
        pin_rt    = prt;
    endtask

    initial begin
        // Reset held two edges with a live writer on the D inputs.
        drive(1, 1, 8, 1, 0, 0, 0, 0, 1, 8, 2);
        step(1, 1, 8, 1, 0,  0, 0, 0,  1, 8, 2,  0, 0, 0, 0);
        step(0, 1, 8, 1, 1,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0);

        // Load-use: lw $8 then addu $3,$8,$0 -> one stall cycle.
        step(0, 1, 0, 0, 0,  0, 0, 0,  1, 8, 2,  1, 0, 0, 0);
        step(0, 1, 8, 1, 1,  0, 1, 1,  1, 3, 1,  1, 1, 0, 0);
        step(0, 1, 8, 1, 1,  0, 1, 1,  1, 3, 1,  1, 0, 0, 0);

        // ALU chain: ori $9 then readers of $9 (rt) and $3 (rs).
        step(0, 1, 0, 0, 1,  0, 0, 1,  1, 9, 1,  1, 0, 0, 0);
        step(0, 1, 0, 0, 1,  9, 1, 1,  1, 4, 1,  1, 0, 0, 0);
        step(0, 1, 3, 1, 1,  9, 1, 1,  1, 4, 1,  1, 0, 3, 2);

        // beq on $10 right behind lw $10 -> two stall cycles, then W forward.
        step(0, 1, 0, 0, 0,  0, 0, 0,  1, 10, 2, 1, 0, 0, 0);
        step(0, 1, 10, 1, 0, 0, 1, 0,  0, 0, 0,  1, 1, 0, 0);
        step(0, 1, 10, 1, 0, 0, 1, 0,  0, 0, 0,  1, 1, 0, 0);
        step(0, 1, 10, 1, 0, 0, 1, 0,  0, 0, 0,  1, 0, 3, 0);

        // Shadowing: ori $5 then lui $5 (result ready in E); reader sees entry 1.
        step(0, 1, 0, 0, 1,  0, 0, 1,  1, 5, 1,  0, 0, 0, 0);
        step(0, 1, 0, 0, 1,  0, 0, 1,  1, 5, 0,  0, 0, 0, 0);
        step(0, 1, 5, 1, 1,  5, 1, 1,  0, 0, 0,  1, 0, 1, 1);

        // $0 writer never tracked; a $0 reader never stalls or forwards.
        step(0, 1, 0, 0, 0,  0, 0, 0,  1, 0, 2,  0, 0, 0, 0);
        step(0, 1, 0, 1, 0,  0, 1, 0,  0, 0, 0,  1, 0, 0, 0);

        // Invalid D slot never matches a live writer.
        step(0, 1, 0, 0, 0,  0, 0, 0,  1, 7, 2,  0, 0, 0, 0);
        step(0, 0, 7, 1, 0,  7, 1, 0,  0, 0, 0,  1, 0, 0, 0);

        // Reset mid-operation: scoreboard empties.
        step(0, 1, 0, 0, 0,  0, 0, 0,  1, 8, 2,  0, 0, 0, 0);
        step(1, 1, 8, 1, 0,  0, 0, 0,  0, 0, 0,  1, 1, 0, 0);
        step(0, 1, 8, 1, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0);

        // Three load-use pairs.
        for (int p = 0; p < 3; p++) begin
            step(0, 1, 0, 0, 0,  0, 0, 0,  1, 8, 2,  0, 0, 0, 0);
            step(0, 1, 8, 1, 1,  0, 0, 0,  0, 0, 0,  1, 1, 0, 0);
            step(0, 1, 8, 1, 1,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0);
`ifdef HAZARD_STATS_EN
        pin_cnt = 3;
`endif
        step(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
        pin_cnt = -1;
`endif
        step(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0);
`ifdef HAZARD_STATS_EN
        pin_cnt = 0;
`endif
        @(posedge Clk);
        @(negedge Clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
